// File: rtl/axi_wr_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_slave_mem
// Brief    : AXI3 write-path slave (AW/W/B) storing bursts into word memory.
//            Optional macro AXI_WR_BP_EN adds LFSR-driven ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_slave_mem #(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        aclk,
  input  logic        arst,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awid,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [3:0]  wid,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_rdata
);

  localparam int          IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] c_DEPTH = 32'(MEM_DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_DATA = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  localparam logic [1:0] c_FIXED = 2'b00;
  localparam logic [1:0] c_WRAP  = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [3:0]  id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        cfg_err_q, cfg_err_d;
  logic        en_q;

  logic        gate;
  logic        aw_hs, w_hs;
  logic        aw_cfg_err;
  logic        last_beat, beat_oor, beat_err, wr_en;
  logic [31:0] beat_off, dbg_off;
  logic [31:0] size_bytes, aligned, incr, wrap_mask, next_addr;

  logic [31:0] mem_q [MEM_DEPTH];

`ifdef AXI_WR_BP_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 8,6,5,4
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge aclk) begin
    if (!arst) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end

  assign gate = lfsr_q[0];
`else
  assign gate = 1'b1;
`endif

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  assign aw_cfg_err = (awsize > 3'd2) || (awburst == 2'b11) ||
                      ((awburst == c_WRAP) && !((awlen == 4'd1) || (awlen == 4'd3) ||
                                                (awlen == 4'd7) || (awlen == 4'd15)));

  assign beat_off  = addr_q - BASE_ADDR;
  assign beat_oor  = (addr_q < BASE_ADDR) || ({2'b00, beat_off[31:2]} >= c_DEPTH);
  assign last_beat = (cnt_q == len_q);
  assign beat_err  = cfg_err_q | beat_oor | (wid != id_q) | (wlast != last_beat);
  assign wr_en     = w_hs & ~beat_err & arst;

  always_comb begin
    size_bytes = 32'd1 << size_q;
    aligned    = addr_q & ~(size_bytes - 32'd1);
    incr       = aligned + size_bytes;
    wrap_mask  = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
    case (burst_q)
      c_FIXED: next_addr = addr_q;
      c_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr & wrap_mask);
      default: next_addr = incr;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arst) begin
      state_q <= c_IDLE;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (aw_hs) state_d = c_DATA;
      c_DATA:  if (w_hs && (last_beat || wlast)) state_d = c_RESP;
      c_RESP:  if (bvalid && bready) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = 4'd0;
    bresp   = 2'b00;
    case (state_q)
      c_IDLE: awready = en_q & gate;
      c_DATA: wready  = gate;
      c_RESP: begin
        bvalid = 1'b1;
        bid    = id_q;
        bresp  = err_q ? 2'b10 : 2'b00;
      end
      default: ;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    cfg_err_d = cfg_err_q;
    if (state_q == c_IDLE && aw_hs) begin
      addr_d    = awaddr;
      len_d     = awlen;
      size_d    = awsize;
      burst_d   = awburst;
      id_d      = awid;
      cnt_d     = 4'd0;
      err_d     = 1'b0;
      cfg_err_d = aw_cfg_err;
    end else if (state_q == c_DATA && w_hs) begin
      cnt_d  = cnt_q + 4'd1;
      addr_d = next_addr;
      err_d  = err_q | beat_err;
    end
  end

  always_ff @(posedge aclk) begin
    if (!arst) begin
      addr_q    <= 32'd0;
      len_q     <= 4'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      id_q      <= 4'd0;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Memory contents survive reset; only strobed lanes of error-free beats land
  always_ff @(posedge aclk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem_q[beat_off[IDX_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign dbg_off = dbg_addr - BASE_ADDR;

  always_comb begin
    dbg_rdata = 32'd0;
    if ((dbg_addr >= BASE_ADDR) && ({2'b00, dbg_off[31:2]} < c_DEPTH))
      dbg_rdata = mem_q[dbg_off[IDX_W+1:2]];
  end

  logic unused_ok;
  assign unused_ok = ^{awlock, beat_off[1:0], dbg_off[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_slave_mem
// Brief    : Self-checking bench for axi_wr_slave_mem (directed table, corner
//            sequences, random bursts against a byte-level memory model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_slave_mem;

  localparam int          MEM_DEPTH = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
  localparam int          LIMIT     = 200;

  logic        aclk = 1'b0;
  logic        arst = 1'b0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic [1:0]  awlock = '0;
  logic [3:0]  awid = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [3:0]  wid = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] dbg_addr = '0;
  logic [31:0] dbg_rdata;

  always #5 aclk = ~aclk;

  axi_wr_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
    .aclk(aclk), .arst(arst),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awid(awid), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wid(wid), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          stall_seen = 1'b0;
  logic [31:0] model_mem [MEM_DEPTH];

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string name, input logic [31:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(name, dbg_rdata, exp);
  endtask

  // Address of beat k from the burst rules, computed in closed form
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input logic [1:0] burst, input int k);
    int unsigned nb, al, tot, base;
    nb  = 1 << size;
    al  = start / nb * nb;
    tot = (len + 1) * nb;
    if (k == 0 || burst == 2'b00) return start;
    if (burst == 2'b10) begin
      base = start / tot * tot;
      return base + (al - base + k * nb) % tot;
    end
    return al + k * nb;
  endfunction

  function automatic bit cfg_bad(input int len, input int size, input logic [1:0] burst);
    return (size > 2) || (burst == 2'b11) ||
           (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    return (a < BASE_ADDR) || (((a - BASE_ADDR) / 4) >= MEM_DEPTH);
  endfunction

  task automatic do_burst(input string tag, input logic [31:0] addr, input int len, input int size,
                          input logic [1:0] burst, input logic [3:0] id,
                          input logic [31:0] dbase, input logic [31:0] dinc, input logic [3:0] strb,
                          input bit rnd, input int early, input bit nolast, input bit badwid,
                          input int bdelay, output logic [1:0] resp_o, output int lat_o);
    bit          merr, berr, exp_err, last;
    int          n, t0, idx;
    logic [31:0] d, a;
    logic [3:0]  s, w_id;
    logic [1:0]  exp_resp;
    resp_o  = 2'b11;
    lat_o   = -1;
    merr    = cfg_bad(len, size, burst);
    exp_err = 1'b0;
    awaddr  = addr; awlen = len[3:0]; awsize = size[2:0]; awburst = burst;
    awid    = id;   awlock = 2'($urandom); awvalid = 1'b1;
    n = 0;
    while (!awready && n < LIMIT) begin @(negedge aclk); n++; end
    if (n >= LIMIT) begin
      check({tag, " aw timeout"}, 32'd1, 32'd0);
      awvalid = 1'b0;
      return;
    end
    t0 = cyc;
    @(negedge aclk);
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      d    = rnd ? $urandom : dbase + k * dinc;
      s    = rnd ? 4'($urandom) : strb;
      last = (early == k) ? 1'b1 : (k == len && !nolast);
      w_id = badwid ? ~id : id;
      a    = beat_addr(addr, len, size, burst, k);
      wvalid = 1'b1; wdata = d; wstrb = s; wid = w_id; wlast = last;
      n = 0;
      while (!wready && n < LIMIT) begin stall_seen = 1'b1; @(negedge aclk); n++; end
      if (n >= LIMIT) begin
        check({tag, " w timeout"}, 32'd1, 32'd0);
        wvalid = 1'b0;
        return;
      end
      berr = merr || out_of_range(a) || (w_id != id) || (last != (k == len));
      exp_err |= berr;
      if (!berr) begin
        idx = int'((a - BASE_ADDR) / 4);
        for (int i = 0; i < 4; i++)
          if (s[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
      end
      @(negedge aclk);
      if (last) break;
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp_resp = exp_err ? 2'b10 : 2'b00;
    n = 0;
    while (!bvalid && n < LIMIT) begin @(negedge aclk); n++; end
    if (n >= LIMIT) begin
      check({tag, " b timeout"}, 32'd1, 32'd0);
      return;
    end
    lat_o = cyc - t0;
    for (int j = 0; j < bdelay; j++) begin
      @(negedge aclk);
      check({tag, " bvalid hold"}, 32'(bvalid), 32'd1);
      check({tag, " bid hold"}, 32'(bid), 32'(id));
      check({tag, " bresp hold"}, 32'(bresp), 32'(exp_resp));
      check({tag, " awready low"}, 32'(awready), 32'd0);
    end
    check({tag, " bid"}, 32'(bid), 32'(id));
    check({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
    resp_o = bresp;
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          len;
    int          size;
    logic [1:0]  burst;
    logic [3:0]  id;
    logic [31:0] dbase;
    logic [31:0] dinc;
    logic [3:0]  strb;
    int          early;
    bit          nolast;
    bit          badwid;
    logic [1:0]  exp_resp;
    logic [31:0] chk_addr;
    logic [31:0] chk_word;
  } vec_t;

  vec_t        tbl [13];
  logic [1:0]  rsp;
  int          lat;

  initial begin
    tbl[0]  = '{32'h10,  3, 2, 2'b01, 4'd3,  32'h1111_1111, 32'h1111_1111, 4'hF, -1, 0, 0, 2'b00, 32'h1C, 32'h4444_4444};
    tbl[1]  = '{32'h38,  3, 2, 2'b10, 4'd5,  32'hA000_0000, 32'd1, 4'hF, -1, 0, 0, 2'b00, 32'h30, 32'hA000_0002};
    tbl[2]  = '{32'h00,  0, 2, 2'b01, 4'd1,  32'hAABB_CCDD, 32'd0, 4'b0101, -1, 0, 0, 2'b00, 32'h00, 32'h00BB_00DD};
    tbl[3]  = '{32'h400, 0, 2, 2'b01, 4'd2,  32'h1234_5678, 32'd0, 4'hF, -1, 0, 0, 2'b10, 32'h3FC, 32'h0};
    tbl[4]  = '{32'h80,  3, 2, 2'b01, 4'd6,  32'hC000_0000, 32'd1, 4'hF,  1, 0, 0, 2'b10, 32'h80, 32'hC000_0000};
    tbl[5]  = '{32'h90,  0, 2, 2'b01, 4'd7,  32'hDEAD_BEEF, 32'd0, 4'hF, -1, 0, 1, 2'b10, 32'h90, 32'h0};
    tbl[6]  = '{32'hA0,  0, 3, 2'b01, 4'd8,  32'hBAD0_0001, 32'd0, 4'hF, -1, 0, 0, 2'b10, 32'hA0, 32'h0};
    tbl[7]  = '{32'hA4,  0, 2, 2'b11, 4'd9,  32'hBAD0_0002, 32'd0, 4'hF, -1, 0, 0, 2'b10, 32'hA4, 32'h0};
    tbl[8]  = '{32'hA8,  2, 2, 2'b10, 4'd10, 32'hBAD0_0003, 32'd1, 4'hF, -1, 0, 0, 2'b10, 32'hA8, 32'h0};
    tbl[9]  = '{32'hB0,  2, 2, 2'b00, 4'd11, 32'hD000_0000, 32'd1, 4'hF, -1, 0, 0, 2'b00, 32'hB0, 32'hD000_0002};
    tbl[10] = '{32'hC0,  1, 2, 2'b01, 4'd12, 32'hE000_0000, 32'd1, 4'hF, -1, 1, 0, 2'b10, 32'hC0, 32'hE000_0000};
    tbl[11] = '{32'hD1,  2, 0, 2'b01, 4'd13, 32'h0102_0304, 32'h0101_0101, 4'hF, -1, 0, 0, 2'b00, 32'hD0, 32'h0304_0506};
    tbl[12] = '{32'hE4,  1, 2, 2'b10, 4'd14, 32'hF000_0000, 32'd1, 4'hF, -1, 0, 0, 2'b00, 32'hE0, 32'hF000_0001};

    for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge aclk);
    check("rst awready", 32'(awready), 32'd0);
    check("rst wready",  32'(wready),  32'd0);
    check("rst bvalid",  32'(bvalid),  32'd0);
    check("rst bid",     32'(bid),     32'd0);
    check("rst bresp",   32'(bresp),   32'd0);
    arst = 1'b1;
    @(negedge aclk);
`ifndef AXI_WR_BP_EN
    check("awready after release", 32'(awready), 32'd1);
`endif

    // Memory is not reset: fill every word with zero first
    for (int i = 0; i < MEM_DEPTH / 16; i++)
      do_burst("clear", 32'(i * 64), 15, 2, 2'b01, 4'(i), 32'd0, 32'd0, 4'hF, 0, -1, 0, 0, 0, rsp, lat);

    for (int i = 0; i < 13; i++) begin
      do_burst($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].id,
               tbl[i].dbase, tbl[i].dinc, tbl[i].strb, 0, tbl[i].early, tbl[i].nolast, tbl[i].badwid,
               0, rsp, lat);
      check($sformatf("tbl%0d resp", i), 32'(rsp), 32'(tbl[i].exp_resp));
      chk_mem($sformatf("tbl%0d mem", i), tbl[i].chk_addr, tbl[i].chk_word);
`ifndef AXI_WR_BP_EN
      if (i == 0) check("incr latency", 32'(lat), 32'd5);
`endif
    end
    chk_mem("wrap 0x38", 32'h38, 32'hA000_0000);
    chk_mem("wrap 0x34", 32'h34, 32'hA000_0003);
    chk_mem("oor read",  32'h400, 32'h0);

    // bready held low for 5 cycles
    do_burst("bstall", 32'h60, 1, 2, 2'b01, 4'd9, 32'h6000_0000, 32'd1, 4'hF, 0, -1, 0, 0, 5, rsp, lat);
    check("bstall resp", 32'(rsp), 32'd0);
`ifndef AXI_WR_BP_EN
    check("awready after B", 32'(awready), 32'd1);
`endif

    // Reset in the middle of a burst
    awaddr = 32'h100; awlen = 4'd7; awsize = 3'd2; awburst = 2'b01; awid = 4'd4; awvalid = 1'b1;
    begin
      int n = 0;
      while (!awready && n < LIMIT) begin @(negedge aclk); n++; end
      if (n >= LIMIT) check("mid aw timeout", 32'd1, 32'd0);
      @(negedge aclk);
      awvalid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        wvalid = 1'b1; wdata = 32'h7700_0000 + 32'(k); wstrb = 4'hF; wid = 4'd4; wlast = 1'b0;
        n = 0;
        while (!wready && n < LIMIT) begin stall_seen = 1'b1; @(negedge aclk); n++; end
        if (n >= LIMIT) check("mid w timeout", 32'd1, 32'd0);
        model_mem[32'h40 + k] = 32'h7700_0000 + 32'(k);
        @(negedge aclk);
      end
    end
    wvalid = 1'b0;
    arst = 1'b0;
    @(negedge aclk);
    check("mid rst bvalid",  32'(bvalid),  32'd0);
    check("mid rst awready", 32'(awready), 32'd0);
    check("mid rst wready",  32'(wready),  32'd0);
    arst = 1'b1;
    check("release awready", 32'(awready), 32'd0);
    @(negedge aclk);
`ifndef AXI_WR_BP_EN
    check("awready 1 cycle after", 32'(awready), 32'd1);
`endif
    check("no B after abort", 32'(bvalid), 32'd0);
    chk_mem("abort beat0", 32'h100, 32'h7700_0000);
    chk_mem("abort beat1", 32'h104, 32'h7700_0001);
    do_burst("post rst", 32'h108, 0, 2, 2'b01, 4'd2, 32'h0808_0808, 32'd0, 4'hF, 0, -1, 0, 0, 0, rsp, lat);
    check("post rst resp", 32'(rsp), 32'd0);

    // 16-beat INCR
    do_burst("incr16", 32'h200, 15, 2, 2'b01, 4'd12, 32'h5A00_0000, 32'd1, 4'hF, 0, -1, 0, 0, 0, rsp, lat);
    check("incr16 resp", 32'(rsp), 32'd0);
    chk_mem("incr16 last", 32'h23C, 32'h5A00_000F);
`ifdef AXI_WR_BP_EN
    check("bp stall seen", 32'(stall_seen), 32'd1);
`endif

    // Random bursts against the model
    for (int r = 0; r < 40; r++) begin
      int          len, size, early;
      logic [1:0]  burst;
      logic [31:0] addr;
      bit          nolast, badwid;
      burst = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      size  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      if (burst == 2'b10 && $urandom_range(0, 5) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = int'($urandom_range(0, 15));
      addr   = 32'($urandom_range(0, 32'h4FF));
      early  = ($urandom_range(0, 9) == 0 && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
      nolast = ($urandom_range(0, 11) == 0);
      badwid = ($urandom_range(0, 11) == 0);
      do_burst($sformatf("rnd%0d", r), addr, len, size, burst, 4'($urandom), 32'd0, 32'd0, 4'h0,
               1, early, nolast, badwid, int'($urandom_range(0, 2)), rsp, lat);
    end

    for (int i = 0; i < MEM_DEPTH; i++)
      chk_mem($sformatf("scan w%0d", i), 32'(i * 4) + BASE_ADDR, model_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
